ceespu_hazard_unit: RTL

Parametrised hazard and forwarding unit for the ceespu pipeline. It replaces the fixed 2-source, 2-stage forwarding and stall logic that currently sits in the top level.
- Tracks in-flight destination registers in a FWD_DEPTH-entry scoreboard shift register.
- Selects forwarded operands for READ_PORTS decode sources.
- Generates stall/bubble for load-use and busy conditions.
- Sits between decode/regfile and execute.

---
 rtl/ceespu_pkg.sv | 19 +
 rtl/ceespu_fwd_match.sv | 34 +++
 rtl/ceespu_hazard_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ceespu_pkg.sv
// Shared types and constants for the ceespu hazard/forwarding logic.
package ceespu_pkg;

  // Scoreboard stores register indices zero-extended to this width.
  localparam int REG_W_MAX  = 8;
  localparam int REG_ZERO   = 0;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] regD;
    logic                 isLoad;
  } sb_entry_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ceespu_fwd_match.sv
// Per-read-port youngest-match finder over the in-flight scoreboard.
// Purely combinational: yields the forward select and a load-not-ready flag.
module ceespu_fwd_match
  import ceespu_pkg::*;
#(
  parameter int REG_BITS  = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SELW      = sel_width(FWD_DEPTH)
) (
  input  sb_entry_t [FWD_DEPTH-1:0] sb_i,
  input  logic [REG_BITS-1:0]       src_i,
  output logic [SELW-1:0]           sel_o,
  output logic                      load_pend_o
);

  logic [REG_W_MAX-1:0] src_ext;
  assign src_ext = REG_W_MAX'(src_i);

  // Scan oldest to youngest so the lowest matching index is left standing.
  always_comb begin
    sel_o       = SELW'(FWD_SEL_RF);
    load_pend_o = 1'b0;
    if (src_ext != REG_W_MAX'(REG_ZERO)) begin
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
        if (sb_i[i].valid && (sb_i[i].regD == src_ext)) begin
          sel_o       = SELW'(i + 1);
          load_pend_o = sb_i[i].isLoad && (i < LOAD_LAT);
        end
      end
    end
  end

endmodule

// File: rtl/ceespu_hazard_unit.sv
// Hazard and forwarding unit: in-flight scoreboard, operand forwarding, stall/bubble.
// Optional performance counters enabled by defining CEESPU_HAZARD_PERF_EN.
module ceespu_hazard_unit
  import ceespu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_BITS   = 5,
  parameter int READ_PORTS = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  localparam int SELW      = sel_width(FWD_DEPTH)
) (
  input  logic                         I_clk,
  input  logic                         I_rst_n,
  input  logic                         I_dec_valid,
  input  logic [READ_PORTS*REG_BITS-1:0] I_dec_regS,
  input  logic [REG_BITS-1:0]          I_dec_regD,
  input  logic                         I_dec_we,
  input  logic                         I_dec_isLoad,
  input  logic                         I_flush,
  input  logic                         I_ex_busy,
  input  logic                         I_dmem_busy,
  input  logic [READ_PORTS*XLEN-1:0]   I_rf_data,
  input  logic [FWD_DEPTH*XLEN-1:0]    I_stage_data,
  output logic [READ_PORTS*XLEN-1:0]   O_operand,
  output logic [READ_PORTS*SELW-1:0]   O_fwd_sel,
  output logic                         O_stall,
  output logic                         O_bubble
`ifdef CEESPU_HAZARD_PERF_EN
  ,
  output logic [31:0]                  O_stall_cycles,
  output logic [31:0]                  O_bubble_count,
  output logic [31:0]                  O_fwd_count
`endif
);

  if (FWD_DEPTH < 1) begin : g_bad_depth
    $error("ceespu_hazard_unit: FWD_DEPTH must be at least 1");
  end
  if (LOAD_LAT < 0 || LOAD_LAT >= FWD_DEPTH) begin : g_bad_lat
    $error("ceespu_hazard_unit: LOAD_LAT must be in [0, FWD_DEPTH-1]");
  end
  if (REG_BITS > REG_W_MAX) begin : g_bad_regbits
    $error("ceespu_hazard_unit: REG_BITS exceeds scoreboard register field");
  end

  sb_entry_t [FWD_DEPTH-1:0] sb_q, sb_d;
  sb_entry_t                 new_entry;
  logic [READ_PORTS-1:0]     load_pend;
  logic                      busy, load_use, shift;

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_port
    logic [XLEN-1:0] op_p;

    ceespu_fwd_match #(
      .REG_BITS (REG_BITS),
      .FWD_DEPTH(FWD_DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SELW     (SELW)
    ) u_match (
      .sb_i       (sb_q),
      .src_i      (I_dec_regS[gi*REG_BITS +: REG_BITS]),
      .sel_o      (O_fwd_sel[gi*SELW +: SELW]),
      .load_pend_o(load_pend[gi])
    );

    always_comb begin
      op_p = I_rf_data[gi*XLEN +: XLEN];
      for (int i = 0; i < FWD_DEPTH; i++) begin
        if (O_fwd_sel[gi*SELW +: SELW] == SELW'(i + 1)) begin
          op_p = I_stage_data[i*XLEN +: XLEN];
        end
      end
    end

    assign O_operand[gi*XLEN +: XLEN] = op_p;
  end

  assign busy     = I_ex_busy | I_dmem_busy;
  assign load_use = I_dec_valid & (|load_pend);

  // Busy freezes everything (flush waits); flush and load-use both push a bubble entry.
  always_comb begin
    O_stall   = 1'b0;
    O_bubble  = 1'b0;
    shift     = 1'b1;
    new_entry = '0;
    if (busy) begin
      O_stall = 1'b1;
      shift   = 1'b0;
    end else if (I_flush) begin
      new_entry = '0;
    end else if (load_use) begin
      O_stall  = 1'b1;
      O_bubble = 1'b1;
    end else begin
      new_entry.valid  = I_dec_valid & I_dec_we & (I_dec_regD != REG_BITS'(REG_ZERO));
      new_entry.regD   = REG_W_MAX'(I_dec_regD);
      new_entry.isLoad = I_dec_isLoad;
    end

    sb_d = sb_q;
    if (shift) begin
      sb_d[0] = new_entry;
      for (int i = 1; i < FWD_DEPTH; i++) begin
        sb_d[i] = sb_q[i-1];
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

`ifdef CEESPU_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] bubble_count_q, bubble_count_d;
  logic [31:0] fwd_count_q, fwd_count_d;
  logic        fwd_issue;

  // Only a real instruction leaving decode this cycle counts as a forwarded issue.
  assign fwd_issue = ~busy & ~I_flush & ~load_use & I_dec_valid & (|O_fwd_sel);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    bubble_count_d = bubble_count_q;
    fwd_count_d    = fwd_count_q;
    if (O_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (O_bubble && (bubble_count_q != '1)) bubble_count_d = bubble_count_q + 32'd1;
    if (fwd_issue && (fwd_count_q != '1)) fwd_count_d = fwd_count_q + 32'd1;
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
      fwd_count_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
      fwd_count_q    <= fwd_count_d;
    end
  end

  assign O_stall_cycles = stall_cycles_q;
  assign O_bubble_count = bubble_count_q;
  assign O_fwd_count    = fwd_count_q;
`endif

endmodule
